// File: rtl/sms_card_dot_receiver.sv
// Dot-AND receiver for two open-collector lines: synchronize, debounce-filter,
// detect edges and drive a gated set/toggle trigger with a glitch counter.
module sms_card_dot_receiver #(
   parameter int unsigned SYNC_STAGES   = 2,
   parameter int unsigned FILTER_CYCLES = 3
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       line_a,
   input  logic       line_b,
   input  logic       gate,
   input  logic       toggle,
   input  logic       trig_clr,
   output logic       level,
   output logic       fall,
   output logic       rise,
   output logic       trig,
   output logic       trig_n,
   output logic [7:0] glitch_cnt
);

   localparam logic [3:0] CNT_LAST = 4'(FILTER_CYCLES - 1);

   logic [SYNC_STAGES-1:0] sync_a_q, sync_b_q;
   logic                   s;
   logic [3:0]             cnt_q, cnt_d;
   logic                   level_q, level_d;
   logic                   level_dly_q;
   logic [7:0]             glitch_q, glitch_d;
   logic                   trig_q, trig_d;

   // Lines idle high, so every synchronizer stage resets to 1.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_a_q <= '1;
         sync_b_q <= '1;
      end else begin
         sync_a_q <= {sync_a_q[SYNC_STAGES-2:0], line_a};
         sync_b_q <= {sync_b_q[SYNC_STAGES-2:0], line_b};
      end
   end

   assign s = sync_a_q[SYNC_STAGES-1] & sync_b_q[SYNC_STAGES-1];

   always_comb begin
      cnt_d    = cnt_q;
      level_d  = level_q;
      glitch_d = glitch_q;
      if (s != level_q) begin
         if (cnt_q >= CNT_LAST) begin
            level_d = s;
            cnt_d   = '0;
         end else begin
            cnt_d = cnt_q + 4'd1;
         end
      end else begin
         cnt_d = '0;
         // A partially counted transition that fell back is a rejected glitch.
         if (cnt_q != '0 && glitch_q != '1)
            glitch_d = glitch_q + 8'd1;
      end
   end

   always_comb begin
      trig_d = trig_q;
      if (trig_clr)
         trig_d = 1'b0;
      else if (fall && gate)
         trig_d = toggle ? ~trig_q : 1'b1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q       <= '0;
         level_q     <= 1'b1;
         level_dly_q <= 1'b1;
         glitch_q    <= '0;
         trig_q      <= 1'b0;
      end else begin
         cnt_q       <= cnt_d;
         level_q     <= level_d;
         level_dly_q <= level_q;
         glitch_q    <= glitch_d;
         trig_q      <= trig_d;
      end
   end

   assign level      = level_q;
   assign fall       = level_dly_q & ~level_q;
   assign rise       = ~level_dly_q & level_q;
   assign trig       = trig_q;
   assign trig_n     = ~trig_q;
   assign glitch_cnt = glitch_q;

endmodule

// File: tb/tb_sms_card_dot_receiver.sv
// Scoreboard bench for sms_card_dot_receiver at default parameters.
module tb_sms_card_dot_receiver;

   logic       clk = 1'b0;
   logic       rst_n, line_a, line_b, gate, toggle, trig_clr;
   logic       level, fall, rise, trig, trig_n;
   logic [7:0] glitch_cnt;

   int compared   = 0;
   int mismatched = 0;

   typedef struct {
      bit is_fall;
      bit chk_trig;
      bit trig_exp;
   } ev_t;

   ev_t exp_q[$];
   bit  pend_trig = 1'b0;
   bit  pend_val  = 1'b0;

   sms_card_dot_receiver #(.SYNC_STAGES(2), .FILTER_CYCLES(3)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .line_a     (line_a),
      .line_b     (line_b),
      .gate       (gate),
      .toggle     (toggle),
      .trig_clr   (trig_clr),
      .level      (level),
      .fall       (fall),
      .rise       (rise),
      .trig       (trig),
      .trig_n     (trig_n),
      .glitch_cnt (glitch_cnt)
   );

   always #5 clk = ~clk;

   initial begin
      #1ms;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   // Pops one expectation per observed pulse; trig is checked one edge later.
   always @(negedge clk) begin
      if (pend_trig) begin
         pend_trig = 1'b0;
         compared++;
         if (trig !== pend_val) begin
            mismatched++;
            $display("FAIL trig_after_fall: got %b expected %b at %0t", trig, pend_val, $time);
         end
      end
      if (rst_n === 1'b1 && (fall === 1'b1 || rise === 1'b1)) begin
         compared++;
         if (exp_q.size() == 0) begin
            mismatched++;
            $display("FAIL unexpected_pulse: fall=%b rise=%b expected none at %0t", fall, rise, $time);
         end else begin
            ev_t e;
            e = exp_q.pop_front();
            if (fall !== e.is_fall || rise !== !e.is_fall) begin
               mismatched++;
               $display("FAIL pulse_kind: fall=%b rise=%b expected fall=%b at %0t",
                        fall, rise, e.is_fall, $time);
            end
            if (e.chk_trig) begin
               pend_trig = 1'b1;
               pend_val  = e.trig_exp;
            end
         end
      end
   end

   task automatic push(input bit is_fall, input bit chk, input bit texp);
      ev_t e;
      e.is_fall  = is_fall;
      e.chk_trig = chk;
      e.trig_exp = texp;
      exp_q.push_back(e);
   endtask

   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic check_bit(input string name, input logic got, input logic want);
      compared++;
      if (got !== want) begin
         mismatched++;
         $display("FAIL %s: got %b expected %b at %0t", name, got, want, $time);
      end
   endtask

   task automatic test_reset;
      rst_n = 1'b0; line_a = 1'b1; line_b = 1'b1;
      gate = 1'b1; toggle = 1'b0; trig_clr = 1'b0;
      cyc(3);
      check_bit("reset_level", level, 1'b1);
      check_bit("reset_fall", fall, 1'b0);
      check_bit("reset_rise", rise, 1'b0);
      check_bit("reset_trig", trig, 1'b0);
      check_bit("reset_trig_n", trig_n, 1'b1);
      compared++;
      if (glitch_cnt !== 8'd0) begin
         mismatched++;
         $display("FAIL reset_glitch: got %0d expected 0", glitch_cnt);
      end
      rst_n = 1'b1;
      cyc(8);
   endtask

   task automatic test_clean_edge;
      gate = 1'b1; toggle = 1'b0;
      line_a = 1'b0;
      push(1'b1, 1'b1, 1'b1);
      cyc(4);
      check_bit("latency_edge4_level", level, 1'b1);
      cyc(1);
      check_bit("latency_edge5_level", level, 1'b0);
      check_bit("latency_edge5_fall", fall, 1'b1);
      cyc(1);
      check_bit("fall_one_cycle", fall, 1'b0);
      cyc(4);
      line_a = 1'b1;
      push(1'b0, 1'b1, 1'b1);
      cyc(8);
      compared++;
      if (glitch_cnt !== 8'd0) begin
         mismatched++;
         $display("FAIL clean_glitch: got %0d expected 0", glitch_cnt);
      end
   endtask

   task automatic test_glitch;
      int gexp;
      gexp = 0;
      for (int i = 0; i < 300; i++) begin
         line_b = 1'b0;
         cyc(2);
         line_b = 1'b1;
         cyc(4);
         if (gexp < 255) gexp++;
         if (i == 0) begin
            compared++;
            if (glitch_cnt !== 8'(gexp)) begin
               mismatched++;
               $display("FAIL glitch_first: got %0d expected %0d", glitch_cnt, gexp);
            end
            check_bit("glitch_level", level, 1'b1);
         end
      end
      compared++;
      if (glitch_cnt !== 8'(gexp)) begin
         mismatched++;
         $display("FAIL glitch_saturate: got %0d expected %0d", glitch_cnt, gexp);
      end
      check_bit("glitch_level_end", level, 1'b1);
   endtask

   task automatic test_toggle;
      bit tm;
      trig_clr = 1'b1;
      cyc(1);
      trig_clr = 1'b0;
      check_bit("toggle_pre_clear", trig, 1'b0);
      gate = 1'b1; toggle = 1'b1;
      tm = 1'b0;
      for (int p = 0; p < 3; p++) begin
         line_a = 1'b0;
         tm = !tm;
         push(1'b1, 1'b1, tm);
         cyc(6);
         line_a = 1'b1;
         push(1'b0, 1'b1, tm);
         cyc(6);
      end
      cyc(2);
      check_bit("toggle_final", trig, 1'b1);
   endtask

   task automatic test_gate_clear;
      bit seen;
      trig_clr = 1'b1;
      cyc(1);
      trig_clr = 1'b0;
      gate = 1'b0; toggle = 1'b0;
      line_a = 1'b0;
      push(1'b1, 1'b1, 1'b0);
      cyc(8);
      line_a = 1'b1;
      push(1'b0, 1'b1, 1'b0);
      cyc(8);
      gate = 1'b1;
      line_a = 1'b0;
      push(1'b1, 1'b1, 1'b0);
      seen = 1'b0;
      for (int k = 0; k < 12 && !seen; k++) begin
         @(negedge clk);
         if (fall === 1'b1) begin
            trig_clr = 1'b1;
            seen = 1'b1;
         end
      end
      compared++;
      if (!seen) begin
         mismatched++;
         $display("FAIL clear_fall_timeout: fall=%b expected a pulse within 12 cycles", fall);
      end
      cyc(1);
      trig_clr = 1'b0;
      check_bit("clear_priority", trig, 1'b0);
      cyc(4);
      line_a = 1'b1;
      push(1'b0, 1'b1, 1'b0);
      cyc(8);
   endtask

   task automatic test_wired_and;
      gate = 1'b0;
      line_a = 1'b0; line_b = 1'b1;
      push(1'b1, 1'b0, 1'b0);
      cyc(8);
      check_bit("wand_a_low", level, 1'b0);
      line_b = 1'b0;
      cyc(1);
      line_a = 1'b1;
      for (int k = 0; k < 8; k++) begin
         cyc(1);
         check_bit("wand_swap_level", level, 1'b0);
      end
      line_b = 1'b1;
      push(1'b0, 1'b0, 1'b0);
      cyc(8);
      check_bit("wand_release", level, 1'b1);
   endtask

   task automatic test_reset_mid;
      gate = 1'b1; toggle = 1'b0;
      line_a = 1'b0;
      push(1'b1, 1'b1, 1'b1);
      cyc(8);
      line_a = 1'b1;
      push(1'b0, 1'b1, 1'b1);
      cyc(8);
      check_bit("rstmid_trig_before", trig, 1'b1);
      line_a = 1'b0;
      cyc(4);
      rst_n = 1'b0;
      #1;
      check_bit("rstmid_trig", trig, 1'b0);
      check_bit("rstmid_trig_n", trig_n, 1'b1);
      check_bit("rstmid_level", level, 1'b1);
      check_bit("rstmid_fall", fall, 1'b0);
      check_bit("rstmid_rise", rise, 1'b0);
      compared++;
      if (glitch_cnt !== 8'd0) begin
         mismatched++;
         $display("FAIL rstmid_glitch: got %0d expected 0", glitch_cnt);
      end
      line_a = 1'b1;
      cyc(3);
      rst_n = 1'b1;
      cyc(8);
      gate = 1'b0;
      line_a = 1'b0;
      push(1'b1, 1'b1, 1'b0);
      cyc(4);
      check_bit("rstmid_restart_edge4", level, 1'b1);
      cyc(1);
      check_bit("rstmid_restart_edge5", level, 1'b0);
      cyc(3);
      line_a = 1'b1;
      push(1'b0, 1'b0, 1'b0);
      cyc(8);
   endtask

   initial begin
      test_reset();
      test_clean_edge();
      test_glitch();
      test_toggle();
      test_gate_clear();
      test_wired_and();
      test_reset_mid();
      cyc(2);
      compared++;
      if (exp_q.size() != 0) begin
         mismatched++;
         $display("FAIL missing_pulses: got %0d outstanding expected 0", exp_q.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
